vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Shares one single-port framebuffer RAM between VGA scan-out and a host write port, on the 25 MHz pixel clock. Keeps a small prefetch FIFO of pixels ahead of the display pipeline and grants idle RAM cycles to host writes. Sits between `hvsync_generator`/pixel output logic and the framebuffer RAM. Scan-out has priority whenever the FIFO runs low.

## Interface
- `ADDR_W`, 15: framebuffer address width.
- `DATA_W`, 3: pixel width (R,G,B bits).
- `FB_PIXELS`, 19200: pixels per frame (160x120).
- `DEPTH`, 8: prefetch FIFO depth (power of two, ≥4).
- `LOW_WM`, 4: FIFO occupancy below which scan-out fetch beats host writes.

Ports:
- `clk` in 1: 25 MHz pixel clock. All logic runs in this single domain.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at the start of the frame.
- `pix_pop` in 1: consumer takes the FIFO head this cycle.
- `pix_data` out DATA_W: FIFO head, show-ahead.
- `pix_valid` out 1: FIFO not empty.
- `underrun` out 1: sticky; set by a pop while the FIFO is empty; cleared by `frame_start`.
- `wr_req` in 1: host write request. Held with address and data until `wr_ack`.
- `wr_addr` in ADDR_W: host write address.
- `wr_data` in DATA_W: host write data.
- `wr_ack` out 1: one-cycle pulse; the write is on the RAM port this cycle.
- `ram_addr` out ADDR_W: registered RAM address.
- `ram_we` out 1: registered RAM write enable.
- `ram_wdata` out DATA_W: registered RAM write data.
- `ram_rdata` in DATA_W: RAM read data, valid one cycle after the read address is presented.

## Operation
- Two-state fetch FSM:
  - `STOPPED`: state after reset, and after the last pixel of the frame is issued.
  - `FETCH`: entered on `frame_start`.
- `frame_start` (any state):
  - Fetch pointer goes to 0.
  - FIFO is flushed.
  - Any in-flight read is marked to be discarded.
  - `underrun` is cleared.
  - FSM goes to `FETCH`.
- Per-cycle grant, evaluated on registered state:
  - `room = DEPTH - (level + inflight)`.
  - **Video grant:** FSM is `FETCH`, `room>0`, and (`level<LOW_WM` or `!wr_req` or `wr_ack`). Next cycle: `ram_addr`=fetch pointer, `ram_we`=0, `inflight`=1, pointer increments.
  - **Host grant:** no video grant, `wr_req`=1, and `wr_ack`=0. Next cycle: `ram_addr`=`wr_addr`, `ram_wdata`=`wr_data`, `ram_we`=1, `wr_ack`=1.
  - `ram_we` and `wr_ack` are never high in two consecutive cycles for the same request.
  - Otherwise: `ram_we`=0 and `ram_addr` holds its value.
- Fetch pointer:
  - Counts 0..`FB_PIXELS-1`.
  - Issuing address `FB_PIXELS-1` moves the FSM to `STOPPED`. There is no wrap; the next frame restarts at `frame_start`.
- Read return: the cycle after a video read, `ram_rdata` is pushed to the FIFO unless the read was discarded by `frame_start`.
- FIFO:
  - `pix_pop` with `pix_valid`=1 removes the head.
  - Push and pop in the same cycle leave `level` unchanged.
  - `pix_pop` with an empty FIFO sets `underrun`; `pix_data` reads 0 and `level` stays 0.
  - The overflow guard counts in-flight reads, so a push always finds room.
- Simultaneous `frame_start` and `pix_pop`: the flush wins and the pop is ignored.
- A host write to any address is allowed mid-frame. Pixels already in the FIFO are not updated.

## Timing
- Reset values: `pix_data`=0, `pix_valid`=0, `underrun`=0, `wr_ack`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0. Level 0, FSM `STOPPED`.
- Reset asserted mid-transfer:
  - The in-flight read is discarded.
  - A pending `wr_req` is not acknowledged until reset is released and it is granted.
- First-pixel latency with `wr_req`=0:
  - `frame_start` sampled at edge k.
  - `ram_addr`=0 after edge k+1.
  - `pix_valid`=1 after edge k+2.
- Sustained throughput: one pixel per cycle to the consumer with `wr_req`=0.
- Host write latency:
  - 1 cycle from request to `wr_ack` when level ≥ `LOW_WM` or fetch is `STOPPED`.
  - Bounded by the FIFO refill time otherwise.

## Configuration
- `VGA_FB_ARB_UNDERRUN_CNT_EN`: adds output `underrun_cnt` [15:0].
  - Counts empty-FIFO pops and saturates at 16'hFFFF.
  - Cleared by `frame_start` and by reset.
- Without the macro: the port is absent and only the sticky `underrun` flag exists.

## Test plan
- **Reset and idle:** reset, then 20 idle cycles with no `frame_start` → all outputs 0, no RAM activity.
- **Frame fill with a pattern RAM (`rdata`=addr[2:0]):** `frame_start` then continuous `pix_pop` while `pix_valid`=1 → consumer sees 0,1,…,7,0,… for 19200 pixels, `underrun`=0, FSM `STOPPED` afterwards.
- **Host write with FIFO full:** FIFO full, `wr_req` for address 5, data 3'b101 → `wr_ack` and `ram_we` high together next cycle, RAM[5]=5, and never a second ack for the same request.
- **Contention:** `wr_req` held high with continuous pops → fetch wins while level < 4, host writes interleave, and no underrun occurs.
- **Underrun:** pop 3 times on an empty FIFO → `underrun`=1 (and `underrun_cnt`=3 with the macro), both cleared by the next `frame_start`.
- **Mid-frame restart:** `frame_start` while a read is in flight → the in-flight data is dropped and the next pixel delivered comes from address 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between VGA scan-out and a host
// write port, all in the pixel clock domain. A small show-ahead FIFO of
// prefetched pixels is kept in front of the display pipeline; RAM cycles the
// video fetch does not need are granted to host writes. Fetch wins whenever
// the FIFO occupancy is below LOW_WM.
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   frame_start         1-cycle pulse: restart fetch at pixel 0, flush FIFO
//   pix_pop             consumer takes the FIFO head this cycle
//   pix_data/pix_valid  show-ahead FIFO head / FIFO not empty
//   underrun            sticky: pop on empty FIFO, cleared by frame_start
//   wr_req/addr/data    host write request, held until wr_ack
//   wr_ack              1-cycle pulse: the write is on the RAM port
//   ram_addr/we/wdata   registered RAM port
//   ram_rdata           RAM read data, sampled one cycle after ram_addr
//
// Optional build macro VGA_FB_ARB_UNDERRUN_CNT_EN adds underrun_cnt[15:0],
// a saturating count of empty-FIFO pops, cleared by frame_start and reset.

module vga_fb_arbiter #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned FB_PIXELS = 19200,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LOW_WM    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    STOPPED = 1'b0,
    FETCH   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              inflight_q, inflight_d;
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [LW-1:0] occ;
  logic          vid_grant, host_grant, push, pop, empty_pop;

  always_comb begin
    occ        = level_q + LW'(inflight_q);
    // A frame_start edge only resets the pointer; the first fetch of the new
    // frame is issued on the following edge, so no stale address escapes.
    vid_grant  = (state_q == FETCH) && (occ < LW'(DEPTH)) &&
                 ((level_q < LW'(LOW_WM)) || !wr_req || wr_ack_q) &&
                 !frame_start;
    host_grant = !vid_grant && wr_req && !wr_ack_q;
    // A read in flight across frame_start belongs to the old frame: drop it.
    push       = inflight_q && !frame_start;
    pop        = pix_pop && (level_q != '0) && !frame_start;
    empty_pop  = pix_pop && (level_q == '0) && !frame_start;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    level_d     = level_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    underrun_d  = underrun_q;
    inflight_d  = vid_grant;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    wr_ack_d    = 1'b0;

    if (frame_start) begin
      state_d    = FETCH;
      ptr_d      = '0;
      level_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      underrun_d = 1'b0;
    end else begin
      level_d = level_q + LW'(push) - LW'(pop);
      if (pop)       rd_d = rd_q + AW'(1);
      if (push)      wr_d = wr_q + AW'(1);
      if (empty_pop) underrun_d = 1'b1;
    end

    if (vid_grant) begin
      ram_addr_d = ptr_q;
      ptr_d      = ptr_q + ADDR_W'(1);
      if (ptr_q == ADDR_W'(FB_PIXELS - 1)) state_d = STOPPED;
    end else if (host_grant) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      ram_we_d    = 1'b1;
      wr_ack_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= STOPPED;
      ptr_q       <= '0;
      level_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      inflight_q  <= 1'b0;
      underrun_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      level_q     <= level_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      inflight_q  <= inflight_d;
      underrun_q  <= underrun_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while level_q > 0.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_q] <= ram_rdata;
  end

  assign pix_valid = (level_q != '0);
  assign pix_data  = pix_valid ? mem_q[rd_q] : '0;
  assign underrun  = underrun_q;
  assign wr_ack    = wr_ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (frame_start) cnt_d = '0;
    else if (empty_pop && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign underrun_cnt = cnt_q;
`endif

endmodule
